bullet_frame_scheduler: RTL and testbench

//  Per-frame sequencer and port arbiter for the shared bullet memory. During active video
//  it grants the memory read port to the pixel renderer. In vertical blanking it runs the

---
 rtl/bullet_frame_scheduler_pkg.sv | 50 +++++
 rtl/bullet_frame_scheduler_fire_latch.sv | 62 ++++++
 rtl/bullet_frame_scheduler.sv | 144 ++++++++++++++
 tb/tb_bullet_frame_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_frame_scheduler_pkg.sv
// rtl/bullet_frame_scheduler_pkg.sv - shared encodings for the bullet frame scheduler
package bullet_frame_scheduler_pkg;

  localparam logic [1:0] GRANT_RENDER = 2'd0;
  localparam logic [1:0] GRANT_CLEAN  = 2'd1;
  localparam logic [1:0] GRANT_INSERT = 2'd2;
  localparam logic [1:0] GRANT_MOVE   = 2'd3;

  typedef enum logic [2:0] {
    ST_RENDER = 3'd0,
    ST_CLEAN  = 3'd1,
    ST_INSERT = 3'd2,
    ST_MOVE   = 3'd3,
    ST_IDLE   = 3'd4
  } state_t;

  // Bullet word: valid in bit 0, x above it, y on top.
  localparam int BULLET_W = 24;
  localparam int BW_VALID = 0;
  localparam int BW_X_LSB = 1;
  localparam int BW_X_MSB = 12;
  localparam int BW_Y_LSB = 13;
  localparam int BW_Y_MSB = 23;

  localparam int WD_W = 13;

  function automatic logic [BULLET_W-1:0] pack_bullet(input logic [11:0] x,
                                                      input logic [10:0] y);
    logic [BULLET_W-1:0] w;
    w                   = '0;
    w[BW_VALID]         = 1'b1;
    w[BW_X_MSB:BW_X_LSB] = x;
    w[BW_Y_MSB:BW_Y_LSB] = y;
    return w;
  endfunction

  function automatic logic [1:0] grant_of(input state_t s);
    case (s)
      ST_CLEAN:  return GRANT_CLEAN;
      ST_INSERT: return GRANT_INSERT;
      ST_MOVE:   return GRANT_MOVE;
      default:   return GRANT_RENDER;
    endcase
  endfunction

  function automatic logic is_phase(input state_t s);
    return (s == ST_CLEAN) || (s == ST_INSERT) || (s == ST_MOVE);
  endfunction

endpackage

// File: rtl/bullet_frame_scheduler_fire_latch.sv
// rtl/bullet_frame_scheduler_fire_latch.sv - fire edge capture, pending shot and drop counter
module bullet_frame_scheduler_fire_latch
  import bullet_frame_scheduler_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fire,
  input  logic [11:0]         x_axis,
  input  logic [10:0]         y_axis,
  input  logic                consume,
  output logic                fire_valid,
  output logic [BULLET_W-1:0] fire_data,
  output logic [DROP_W-1:0]   dropped
);

  logic                fire_prev_q, fire_prev_d;
  logic                valid_q, valid_d;
  logic [BULLET_W-1:0] data_q, data_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                fall;

  always_comb begin
    fall        = fire_prev_q & ~fire;
    fire_prev_d = fire;
    valid_d     = valid_q;
    data_d      = data_q;
    drop_d      = drop_q;
    // A shot arriving as the pending one is consumed becomes the new pending shot.
    if (consume) begin
      valid_d = fall;
      if (fall) data_d = pack_bullet(x_axis, y_axis);
    end else if (fall) begin
      if (!valid_q) begin
        valid_d = 1'b1;
        data_d  = pack_bullet(x_axis, y_axis);
      end else if (!(&drop_q)) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fire_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      drop_q      <= '0;
    end else begin
      fire_prev_q <= fire_prev_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      drop_q      <= drop_d;
    end
  end

  assign fire_valid = valid_q;
  assign fire_data  = data_q;
  assign dropped    = drop_q;

endmodule

// File: rtl/bullet_frame_scheduler.sv
// rtl/bullet_frame_scheduler.sv - vblank update sequencer and bullet memory port arbiter
module bullet_frame_scheduler
  import bullet_frame_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int DROP_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              vblank,
  input  logic              fire,
  input  logic [11:0]       x_axis,
  input  logic [10:0]       y_axis,
  input  logic              done_clean,
  input  logic              done_insert,
  input  logic              done_move,
  output logic              start_clean,
  output logic              start_insert,
  output logic              start_move,
  output logic [1:0]        grant,
  output logic              calc,
  output logic              fire_valid,
  output logic [23:0]       fire_data,
  output logic              overrun,
  output logic [DROP_W-1:0] dropped
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [1:0]      grant_q, grant_d;
  logic            calc_q, calc_d;
  logic            overrun_q, overrun_d;
  logic            start_clean_q, start_clean_d;
  logic            start_insert_q, start_insert_d;
  logic            start_move_q, start_move_d;
  logic            consume;
  logic            wd_hit;

  bullet_frame_scheduler_fire_latch #(
    .DROP_W (DROP_W)
  ) u_fire_latch (
    .clock      (clock),
    .reset      (reset),
    .fire       (fire),
    .x_axis     (x_axis),
    .y_axis     (y_axis),
    .consume    (consume),
    .fire_valid (fire_valid),
    .fire_data  (fire_data),
    .dropped    (dropped)
  );

  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    consume   = 1'b0;
    wd_hit    = (wd_q == WD_LAST);
    // Losing vblank mid-update beats a done pulse; a done beats the watchdog.
    case (state_q)
      ST_RENDER: begin
        if (frame_start && vblank) state_d = ST_CLEAN;
      end
      ST_CLEAN: begin
        if (!vblank) begin
          state_d   = ST_RENDER;
          overrun_d = 1'b1;
        end else if (done_clean) begin
          state_d = fire_valid ? ST_INSERT : ST_MOVE;
        end else if (wd_hit) begin
          state_d   = ST_IDLE;
          overrun_d = 1'b1;
        end
      end
      ST_INSERT: begin
        if (!vblank) begin
          state_d   = ST_RENDER;
          overrun_d = 1'b1;
        end else if (done_insert) begin
          state_d = ST_MOVE;
          consume = 1'b1;
        end else if (wd_hit) begin
          state_d   = ST_IDLE;
          overrun_d = 1'b1;
        end
      end
      ST_MOVE: begin
        if (!vblank) begin
          state_d   = ST_RENDER;
          overrun_d = 1'b1;
        end else if (done_move) begin
          state_d = ST_IDLE;
        end else if (wd_hit) begin
          state_d   = ST_IDLE;
          overrun_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (!vblank) state_d = ST_RENDER;
      end
      default: state_d = ST_RENDER;
    endcase

    // Registered outputs are computed from the next state so they line up with it.
    grant_d        = grant_of(state_d);
    calc_d         = (state_d != ST_RENDER);
    start_clean_d  = (state_d == ST_CLEAN)  && (state_q != ST_CLEAN);
    start_insert_d = (state_d == ST_INSERT) && (state_q != ST_INSERT);
    start_move_d   = (state_d == ST_MOVE)   && (state_q != ST_MOVE);
    wd_d           = ((state_d != state_q) || !is_phase(state_q)) ? '0 : wd_q + WD_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_RENDER;
      wd_q           <= '0;
      grant_q        <= GRANT_RENDER;
      calc_q         <= 1'b0;
      overrun_q      <= 1'b0;
      start_clean_q  <= 1'b0;
      start_insert_q <= 1'b0;
      start_move_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      grant_q        <= grant_d;
      calc_q         <= calc_d;
      overrun_q      <= overrun_d;
      start_clean_q  <= start_clean_d;
      start_insert_q <= start_insert_d;
      start_move_q   <= start_move_d;
    end
  end

  assign grant        = grant_q;
  assign calc         = calc_q;
  assign overrun      = overrun_q;
  assign start_clean  = start_clean_q;
  assign start_insert = start_insert_q;
  assign start_move   = start_move_q;

endmodule

// File: tb/tb_bullet_frame_scheduler.sv
// tb/tb_bullet_frame_scheduler.sv - self-checking bench for bullet_frame_scheduler
module tb_bullet_frame_scheduler;

  logic        clock;
  logic        reset;
  logic        frame_start;
  logic        vblank;
  logic        fire;
  logic [11:0] x_axis;
  logic [10:0] y_axis;
  logic        done_clean;
  logic        done_insert;
  logic        done_move;
  logic        start_clean;
  logic        start_insert;
  logic        start_move;
  logic [1:0]  grant;
  logic        calc;
  logic        fire_valid;
  logic [23:0] fire_data;
  logic        overrun;
  logic [7:0]  dropped;

  int n_cmp = 0;
  int n_err = 0;

  bullet_frame_scheduler #(
    .TIMEOUT (16),
    .DROP_W  (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .vblank       (vblank),
    .fire         (fire),
    .x_axis       (x_axis),
    .y_axis       (y_axis),
    .done_clean   (done_clean),
    .done_insert  (done_insert),
    .done_move    (done_move),
    .start_clean  (start_clean),
    .start_insert (start_insert),
    .start_move   (start_move),
    .grant        (grant),
    .calc         (calc),
    .fire_valid   (fire_valid),
    .fire_data    (fire_data),
    .overrun      (overrun),
    .dropped      (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observer: history of memory owners and start-pulse cycle counts.
  logic [1:0] glog[$];
  logic [1:0] last_g = 2'd0;
  int n_sc = 0, n_si = 0, n_sm = 0, n_bad = 0;
  always @(negedge clock) begin
    if (grant !== last_g) begin
      glog.push_back(grant);
      last_g = grant;
    end
    if (start_clean === 1'b1) begin n_sc++; if (grant !== 2'd1) n_bad++; end
    if (start_insert === 1'b1) begin n_si++; if (grant !== 2'd2) n_bad++; end
    if (start_move === 1'b1) begin n_sm++; if (grant !== 2'd3) n_bad++; end
  end

  // Reference model of the shot latch.
  logic        ref_prev = 1'b0;
  logic        ref_pending = 1'b0;
  logic [23:0] ref_data = '0;
  int          ref_dropped = 0;

  function automatic logic [23:0] shot_word(input logic [11:0] x, input logic [10:0] y);
    return {y, x, 1'b1};
  endfunction

  task automatic model_step();
    logic fall;
    if (reset) begin
      ref_prev = 1'b0; ref_pending = 1'b0; ref_data = '0; ref_dropped = 0;
    end else begin
      fall = ref_prev && !fire;
      if (done_insert && ref_pending) begin
        ref_pending = fall;
        if (fall) ref_data = shot_word(x_axis, y_axis);
      end else if (fall) begin
        if (!ref_pending) begin
          ref_pending = 1'b1;
          ref_data = shot_word(x_axis, y_axis);
        end else if (ref_dropped < 255) begin
          ref_dropped++;
        end
      end
      ref_prev = fire;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_fv"}, 32'(fire_valid), 32'(ref_pending));
    chk({tag, "_fd"}, 32'(fire_data), 32'(ref_data));
    chk({tag, "_drop"}, 32'(dropped), 32'(ref_dropped));
  endtask

  task automatic chk_log(input string tag, input int idx0, input int exp_n, input int exp_v);
    int v;
    v = 0;
    for (int i = idx0; i < glog.size(); i++) v = (v << 2) | int'(glog[i]);
    chk({tag, "_glog_n"}, 32'(glog.size() - idx0), 32'(exp_n));
    chk({tag, "_glog_v"}, 32'(v), 32'(exp_v));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_calc"}, 32'(calc), 0);
    chk({tag, "_starts"}, 32'({start_clean, start_insert, start_move}), 0);
    chk({tag, "_fv"}, 32'(fire_valid), 0);
    chk({tag, "_fd"}, 32'(fire_data), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
    chk({tag, "_drop"}, 32'(dropped), 0);
  endtask

  task automatic shoot(input logic [11:0] x, input logic [10:0] y, input int hold);
    x_axis = x; y_axis = y; fire = 1'b0;
    idle(hold);
    fire = 1'b1;
    x_axis = 12'($urandom); y_axis = 11'($urandom);
    tick();
  endtask

  // One well-behaved frame with random engine latencies; no firing inside it.
  task automatic frame(input string tag);
    bit ins;
    int idx0;
    ins = ref_pending;
    idx0 = glog.size();
    vblank = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk({tag, "_sc"}, 32'(start_clean), 1);
    idle($urandom_range(0, 11));
    done_clean = 1'b1; tick(); done_clean = 1'b0;
    if (ins) begin
      chk({tag, "_gi"}, 32'(grant), 2);
      idle($urandom_range(0, 11));
      done_insert = 1'b1; tick(); done_insert = 1'b0;
      chk({tag, "_fv_clr"}, 32'(fire_valid), 0);
    end
    chk({tag, "_gm"}, 32'(grant), 3);
    idle($urandom_range(0, 11));
    done_move = 1'b1; tick(); done_move = 1'b0;
    chk({tag, "_idle"}, 32'({calc, grant}), 32'(3'b100));
    idle(2);
    vblank = 1'b0; tick();
    chk({tag, "_calc_end"}, 32'(calc), 0);
    chk_log(tag, idx0, ins ? 4 : 3, ins ? 8'h6C : 6'h1C);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int idx0, sc0, si0, sm0;
    logic [11:0] bx;
    logic [10:0] by;
    logic [23:0] held;

    reset = 1'b1; frame_start = 1'b0; vblank = 1'b0; fire = 1'b1;
    x_axis = '0; y_axis = '0; done_clean = 1'b0; done_insert = 1'b0; done_move = 1'b0;

    // Reset state
    idle(3);
    chk_all_zero("reset");
    reset = 1'b0;
    idle(2);
    chk_all_zero("post_reset");

    // Frame without a shot
    idx0 = glog.size(); sc0 = n_sc; si0 = n_si; sm0 = n_sm;
    vblank = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t1_grant_clean", 32'(grant), 1);
    chk("t1_start_clean", 32'(start_clean), 1);
    chk("t1_calc", 32'(calc), 1);
    tick();
    chk("t1_start_clean_once", 32'(start_clean), 0);
    idle(8);
    done_clean = 1'b1; tick(); done_clean = 1'b0;
    chk("t1_grant_move", 32'(grant), 3);
    chk("t1_start_move", 32'(start_move), 1);
    done_clean = 1'b1; tick(); done_clean = 1'b0;
    chk("t1_foreign_done", 32'(grant), 3);
    idle(7);
    done_move = 1'b1; tick(); done_move = 1'b0;
    chk("t1_idle_grant", 32'(grant), 0);
    idle(3);
    chk("t1_idle_calc", 32'(calc), 1);
    vblank = 1'b0; tick();
    chk("t1_calc_fall", 32'(calc), 0);
    chk_log("t1", idx0, 3, 6'h1C);
    chk("t1_n_start_clean", 32'(n_sc - sc0), 1);
    chk("t1_n_start_insert", 32'(n_si - si0), 0);
    chk("t1_n_start_move", 32'(n_sm - sm0), 1);
    chk("t1_overrun", 32'(overrun), 0);

    // Shot at x=100 y=600, then a frame that inserts it
    shoot(12'd100, 11'd600, 1);
    chk("t2_fire_data", 32'(fire_data), 32'h4B00C9);
    chk_model("t2_capture");
    idx0 = glog.size();
    vblank = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0;
    idle(3);
    done_clean = 1'b1; tick(); done_clean = 1'b0;
    chk("t2_grant_insert", 32'(grant), 2);
    chk("t2_start_insert", 32'(start_insert), 1);
    idle(4);
    done_insert = 1'b1; tick(); done_insert = 1'b0;
    chk("t2_fv_clear", 32'(fire_valid), 0);
    chk("t2_grant_move", 32'(grant), 3);
    idle(2);
    done_move = 1'b1; tick(); done_move = 1'b0;
    idle(1);
    vblank = 1'b0; tick();
    chk_log("t2", idx0, 4, 8'h6C);

    // New shot arriving on the same cycle as done_insert
    shoot(12'($urandom), 11'($urandom), $urandom_range(1, 3));
    chk_model("t2b_first");
    vblank = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0;
    idle(2);
    done_clean = 1'b1; tick(); done_clean = 1'b0;
    idle(1);
    bx = 12'($urandom); by = 11'($urandom);
    x_axis = bx; y_axis = by; fire = 1'b0; done_insert = 1'b1; tick();
    done_insert = 1'b0; fire = 1'b1;
    chk("t2b_fv_kept", 32'(fire_valid), 1);
    chk("t2b_fd_new", 32'(fire_data), 32'(shot_word(bx, by)));
    chk_model("t2b_model");
    tick();
    done_move = 1'b1; tick(); done_move = 1'b0;
    vblank = 1'b0; tick();
    frame("t2c");

    // Drops while a shot is pending
    shoot(12'($urandom), 11'($urandom), 1);
    held = ref_data;
    shoot(12'($urandom), 11'($urandom), 1);
    chk("t3_dropped_one", 32'(dropped), 1);
    chk("t3_first_kept", 32'(fire_data), 32'(held));
    shoot(12'($urandom), 11'($urandom), 6);
    chk_model("t3_hold_low");
    for (int i = 0; i < 300; i++) shoot(12'($urandom), 11'($urandom), $urandom_range(1, 2));
    chk("t3_saturated", 32'(dropped), 255);
    chk_model("t3_model");

    // Watchdog in CLEAN
    idx0 = glog.size(); sm0 = n_sm;
    vblank = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0;
    idle(14);
    tick();
    chk("t4_no_overrun_yet", 32'(overrun), 0);
    tick();
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_idle", 32'({calc, grant}), 32'(3'b100));
    chk("t4_fv_kept", 32'(fire_valid), 1);
    done_move = 1'b1; tick(); done_move = 1'b0;
    idle(3);
    chk("t4_still_idle", 32'({calc, grant}), 32'(3'b100));
    vblank = 1'b0; tick();
    chk("t4_render", 32'(calc), 0);
    chk("t4_no_start_move", 32'(n_sm - sm0), 0);
    chk_log("t4", idx0, 2, 4'h4);
    idle(2);
    chk("t4_sticky", 32'(overrun), 1);
    chk_model("t4_model");

    reset = 1'b1; tick(); reset = 1'b0;
    chk_all_zero("reset2");
    tick();

    // frame_start without vblank, then vblank lost during MOVE
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t5_ignored_fs", 32'({calc, grant}), 0);
    vblank = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0;
    idle($urandom_range(0, 10));
    done_clean = 1'b1; tick(); done_clean = 1'b0;
    chk("t5_grant_move", 32'(grant), 3);
    idle(3);
    chk("t5_no_overrun", 32'(overrun), 0);
    vblank = 1'b0; tick();
    chk("t5_overrun", 32'(overrun), 1);
    chk("t5_grant0", 32'(grant), 0);
    chk("t5_calc0", 32'(calc), 0);
    idle(2);
    chk("t5_stay_render", 32'({overrun, calc, grant}), 32'(4'b1000));

    // Reset in the middle of INSERT
    shoot(12'($urandom), 11'($urandom), $urandom_range(1, 3));
    chk_model("t6_shot");
    vblank = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0;
    idle(2);
    done_clean = 1'b1; tick(); done_clean = 1'b0;
    chk("t6_grant_insert", 32'(grant), 2);
    idle(2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all_zero("t6_reset");
    tick();
    chk("t6_render", 32'({calc, grant}), 0);
    frame("t6_after");

    for (int k = 0; k < 3; k++) begin
      shoot(12'($urandom), 11'($urandom), $urandom_range(1, 3));
      chk_model("rnd_shot");
      frame("rnd_frame");
      chk_model("rnd_after");
    end

    chk("start_with_grant", 32'(n_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
